fpu_cvt: RTL and testbench

Multi-cycle integer↔single-precision converter for the FP execute stage, sitting beside the FP comparator on the same `i_rs1` operand bus and writing back through a valid/ready handshake. It implements RV32F `fcvt.w.s`, `fcvt.wu.s`, `fcvt.s.w` and `fcvt.s.wu` with round-to-nearest-even only. Normalisation and alignment are iterative, one bit per cycle, so latency depends on the data.

---
 rtl/fpu_cvt.sv | 147 ++++++++++++++
 tb/tb_fpu_cvt.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fpu_cvt.sv
// fpu_cvt: iterative RV32F int<->single converter (fcvt.w[u].s / fcvt.s.w[u]), RNE only,
// one normalisation/alignment shift per cycle behind a valid/ready handshake.
module fpu_cvt (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_rs1,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_result,
    output logic [4:0]  o_fflags
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
    localparam logic [4:0] NV = 5'b10000;

    state_t      state, state_nx;
    logic [1:0]  op;
    logic        sign;
    logic [63:0] acc;
    logic [7:0]  cnt;

    logic [7:0]  e;
    logic        nan, to_done, direct_round, init_sign;
    logic [31:0] mag_in, init_res;
    logic [4:0]  init_flags;
    logic [63:0] init_acc;
    logic [7:0]  init_cnt;

    // Classification at accept: int->float uses acc[63:32] as m and cnt as the running exponent;
    // float->int uses acc as a 32.32 fixed-point value and cnt as the remaining shift count.
    always_comb begin
        e            = i_rs1[30:23];
        nan          = (e == 8'hFF) && (|i_rs1[22:0]);
        init_sign    = i_rs1[31] & (i_op != 2'b11);
        mag_in       = (i_op == 2'b10 && i_rs1[31]) ? -i_rs1 : i_rs1;
        init_res     = '0;
        init_flags   = '0;
        to_done      = 1'b0;
        init_acc     = {mag_in, 32'b0};
        init_cnt     = 8'd158;
        direct_round = mag_in[31];
        if (i_op[1]) begin
            to_done = (mag_in == 32'b0);
        end else begin
            init_acc     = {32'b0, 1'b1, i_rs1[22:0], 8'b0};
            init_cnt     = e - 8'd126;
            direct_round = (e == 8'd126);
            if (nan || (!i_rs1[31] && e >= (i_op[0] ? 8'd159 : 8'd158))) begin
                to_done    = 1'b1;
                init_res   = i_op[0] ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
                init_flags = NV;
            end else if (i_rs1[31] && e >= 8'd158) begin
                to_done    = 1'b1;
                init_res   = i_op[0] ? 32'h0 : 32'h8000_0000;
                init_flags = (!i_op[0] && i_rs1 == 32'hCF00_0000) ? 5'b0 : NV;
            end else if (e < 8'd126) begin
                to_done    = 1'b1;
                init_flags = {4'b0, |i_rs1[30:0]};
            end
        end
    end

    logic        g, st, inc;
    logic [23:0] fsum;
    logic [32:0] isum;
    logic [31:0] rnd_res;
    logic [4:0]  rnd_flags;

    always_comb begin
        g         = op[1] ? acc[39] : acc[31];
        st        = op[1] ? |acc[38:32] : |acc[30:0];
        inc       = g & (st | (op[1] ? acc[40] : acc[32]));
        fsum      = {1'b0, acc[62:40]} + {23'b0, inc};
        isum      = {1'b0, acc[63:32]} + {32'b0, inc};
        rnd_flags = {4'b0, g | st};
        rnd_res   = op[1] ? {sign, cnt + {7'b0, fsum[23]}, fsum[22:0]}
                          : (sign ? -isum[31:0] : isum[31:0]);
        if (!op[1]) begin
            if (!op[0] && !sign && isum >= 33'h0_8000_0000) begin
                rnd_res   = 32'h7FFF_FFFF;
                rnd_flags = NV;
            end else if (!op[0] && sign && isum > 33'h0_8000_0000) begin
                rnd_res   = 32'h8000_0000;
                rnd_flags = NV;
            end else if (op[0] && sign) begin
                rnd_res   = '0;
                rnd_flags = (isum != 33'b0) ? NV : rnd_flags;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = !i_valid ? IDLE : to_done ? DONE : direct_round ? ROUND : NORM;
            NORM:  state_nx = (op[1] ? acc[62] : (cnt == 8'd1)) ? ROUND : NORM;
            ROUND: state_nx = DONE;
            DONE:  state_nx = i_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == IDLE);
        o_valid = (state == DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op       <= '0;
            sign     <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            o_result <= '0;
            o_fflags <= '0;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    op   <= i_op;
                    sign <= init_sign;
                    acc  <= init_acc;
                    cnt  <= init_cnt;
                    if (to_done) begin
                        o_result <= init_res;
                        o_fflags <= init_flags;
                    end
                end
                NORM: begin
                    acc <= acc << 1;
                    cnt <= cnt - 8'd1;
                end
                ROUND: begin
                    o_result <= rnd_res;
                    o_fflags <= rnd_flags;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_cvt.sv
// tb_fpu_cvt: scoreboard bench for fpu_cvt; expected result, flags and latency queued at drive,
// checked when the DUT presents and hands over its result.
module tb_fpu_cvt;
    logic        i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0, i_ready = 1'b1;
    logic [1:0]  i_op = '0;
    logic [31:0] i_rs1 = '0;
    logic        o_ready, o_valid;
    logic [31:0] o_result;
    logic [4:0]  o_fflags;

    fpu_cvt dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_rs1(i_rs1), .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_fflags(o_fflags)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
        int          start;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0, n_fail = 0, cyc = 0;
    bit   seen = 1'b0;

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (o_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 32'(o_valid), 32'd0);
            end else begin
                if (!seen) begin
                    check({sb[0].tag, "_lat"}, 32'(cyc - sb[0].start), 32'(sb[0].lat));
                    seen = 1'b1;
                end
                if (i_ready) begin
                    check({sb[0].tag, "_res"}, o_result, sb[0].res);
                    check({sb[0].tag, "_flags"}, 32'(o_fflags), 32'(sb[0].fl));
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!o_ready && n < 100) begin
            @(posedge i_clk); #1; n++;
        end
        check({tag, "_rdy"}, 32'(o_ready), 32'd1);
    endtask

    task automatic push_drive(input string tag, input logic [1:0] op, input logic [31:0] rs,
                              input logic [31:0] res, input logic [4:0] fl, input int lat);
        exp_t x;
        x.res = res; x.fl = fl; x.lat = lat; x.start = cyc; x.tag = tag;
        sb.push_back(x);
        i_valid = 1'b1; i_op = op; i_rs1 = rs;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge i_clk); #1; n++;
        end
        check({tag, "_drain"}, 32'(sb.size()), 32'd0);
        sb.delete();
        seen = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] rs,
                         input logic [31:0] res, input logic [4:0] fl, input int lat);
        wait_ready(tag);
        push_drive(tag, op, rs, res, fl, lat);
        drain(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_result", o_result, 32'h0);
        check("rst_flags", 32'(o_fflags), 32'h0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        do_op("sw_1",       2'b10, 32'h0000_0001, 32'h3F80_0000, 5'h00, 33);
        do_op("sw_min",     2'b10, 32'h8000_0000, 32'hCF00_0000, 5'h00, 2);
        do_op("sw_m1",      2'b10, 32'hFFFF_FFFF, 32'hBF80_0000, 5'h00, 33);
        do_op("sw_max",     2'b10, 32'h7FFF_FFFF, 32'h4F00_0000, 5'h01, 3);
        do_op("swu_ones",   2'b11, 32'hFFFF_FFFF, 32'h4F80_0000, 5'h01, 2);
        do_op("swu_tie",    2'b11, 32'h0100_0001, 32'h4B80_0000, 5'h01, 9);
        do_op("swu_zero",   2'b11, 32'h0000_0000, 32'h0000_0000, 5'h00, 1);
        do_op("ws_2p5",     2'b00, 32'h4020_0000, 32'h0000_0002, 5'h01, 4);
        do_op("ws_m1p5",    2'b00, 32'hBFC0_0000, 32'hFFFF_FFFE, 5'h01, 3);
        do_op("ws_half",    2'b00, 32'h3F00_0000, 32'h0000_0000, 5'h01, 2);
        do_op("ws_0p75",    2'b00, 32'h3F40_0000, 32'h0000_0001, 5'h01, 2);
        do_op("ws_zero",    2'b00, 32'h0000_0000, 32'h0000_0000, 5'h00, 1);
        do_op("ws_big",     2'b00, 32'h4EFF_FFFF, 32'h7FFF_FF80, 5'h00, 33);
        do_op("ws_2p31",    2'b00, 32'h4F00_0000, 32'h7FFF_FFFF, 5'h10, 1);
        do_op("ws_nan",     2'b00, 32'h7FC0_0000, 32'h7FFF_FFFF, 5'h10, 1);
        do_op("ws_minexact",2'b00, 32'hCF00_0000, 32'h8000_0000, 5'h00, 1);
        do_op("ws_ninf",    2'b00, 32'hFF80_0000, 32'h8000_0000, 5'h10, 1);
        do_op("wus_m3",     2'b01, 32'hC040_0000, 32'h0000_0000, 5'h10, 4);
        do_op("wus_mq",     2'b01, 32'hBE80_0000, 32'h0000_0000, 5'h01, 1);
        do_op("wus_2p32",   2'b01, 32'h4F80_0000, 32'hFFFF_FFFF, 5'h10, 1);
        do_op("wus_big",    2'b01, 32'h4F7F_FFFF, 32'hFFFF_FF00, 5'h00, 34);
        do_op("wus_nan",    2'b01, 32'h7FC0_0000, 32'hFFFF_FFFF, 5'h10, 1);

        // backpressure: result held for 5 cycles while stray requests are offered
        i_ready = 1'b0;
        wait_ready("bp");
        push_drive("bp", 2'b00, 32'h4020_0000, 32'h0000_0002, 5'h01, 4);
        begin
            int n = 0;
            while (!o_valid && n < 100) begin
                @(posedge i_clk); #1; n++;
            end
        end
        check("bp_valid_up", 32'(o_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_res", o_result, 32'h0000_0002);
            check("bp_hold_flags", 32'(o_fflags), 32'h01);
            check("bp_hold_valid", 32'(o_valid), 32'd1);
            check("bp_hold_ready", 32'(o_ready), 32'd0);
            i_valid = (i % 2 == 0); i_op = 2'b10; i_rs1 = 32'h0000_0007;
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        drain("bp");
        check("bp_after_valid", 32'(o_valid), 32'd0);
        check("bp_after_ready", 32'(o_ready), 32'd1);

        // reset during NORM drops the request
        wait_ready("mid_rst");
        i_valid = 1'b1; i_op = 2'b10; i_rs1 = 32'h0000_0001;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (3) begin
            @(posedge i_clk); #1;
        end
        check("mid_busy", 32'(o_ready), 32'd0);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        check("mid_rst_ready", 32'(o_ready), 32'd1);
        check("mid_rst_valid", 32'(o_valid), 32'd0);
        do_op("after_rst", 2'b10, 32'h0000_0003, 32'h4040_0000, 5'h00, 32);

        repeat (3) @(posedge i_clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
